// File: rtl/nco_pkg.sv
// Shared constants, FSM state type and helpers for the multi-voice NCO.
// Default widths here match the nco_voice_scheduler parameter defaults.
package nco_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_FCW_WIDTH  = 24;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_CODE_WIDTH = 14;

  localparam logic [DEF_CODE_WIDTH-1:0] MIDSCALE =
    DEF_CODE_WIDTH'(1) << (DEF_CODE_WIDTH-1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sine_lut.sv
// Combinational sine table, offset-binary code, parabolic half-wave shape.
// Ports: addr (phase, ADDR_WIDTH) -> code (CODE_WIDTH, peak 2^CW-1, trough 1).
module sine_lut #(
  parameter int ADDR_WIDTH = 8,
  parameter int CODE_WIDTH = 14
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [CODE_WIDTH-1:0] code
);

  localparam int HW = ADDR_WIDTH - 1;
  localparam int PW = 2*ADDR_WIDTH + CODE_WIDTH;
  localparam int SH = 2*(ADDR_WIDTH-2);
  localparam logic [CODE_WIDTH-1:0] MID =
    CODE_WIDTH'(1) << (CODE_WIDTH-1);
  localparam logic [PW-1:0] PEAK = PW'(MID) - PW'(1);

  logic [HW-1:0]         x;
  logic [HW:0]           xr;
  logic [PW-1:0]         prod;
  logic [CODE_WIDTH-1:0] mag;

  // x*(half-x) peaks at (half/2)^2 = 2^SH, so scaling by
  // (MID-1) >> SH maps the peak exactly onto full swing.
  always_comb begin
    x    = addr[HW-1:0];
    xr   = (HW+1)'(1 << HW) - {1'b0, x};
    prod = PW'(x) * PW'(xr) * PEAK;
    mag  = CODE_WIDTH'(prod >> SH);
    code = addr[ADDR_WIDTH-1] ? (MID - mag) : (MID + mag);
  end

endmodule

// File: rtl/nco_voice_scheduler.sv
// Time-multiplexes one sine_lut over NUM_VOICES phase accumulators per sample.
// Ports: next_sample strobe, cfg_* write port, code/code_valid out, busy, overrun.
module nco_voice_scheduler
  import nco_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int FCW_WIDTH  = DEF_FCW_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CODE_WIDTH = DEF_CODE_WIDTH,
  localparam int VW = log2_ceil(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  next_sample,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [VW-1:0]         cfg_voice,
  input  logic [FCW_WIDTH-1:0]  cfg_fcw,
  input  logic                  cfg_en,
  input  logic                  cfg_phase_clr,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  code_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int AW = CODE_WIDTH + VW;
  localparam logic [CODE_WIDTH-1:0] MID_CODE =
    CODE_WIDTH'(1) << (CODE_WIDTH-1);
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES-1);

  state_t state;

  logic [FCW_WIDTH-1:0] pa  [NUM_VOICES];
  logic [FCW_WIDTH-1:0] fcw [NUM_VOICES];
  logic [NUM_VOICES-1:0] en;

  logic [VW-1:0]         vidx;
  logic [AW-1:0]         acc;
  logic [ADDR_WIDTH-1:0] lut_addr;
  logic [CODE_WIDTH-1:0] lut_code;
  logic [AW-1:0]         contrib;
  logic                  cfg_fire;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cfg_fire  = cfg_valid && cfg_ready;

  // Lookup uses the pre-increment phase of the voice being visited.
  assign lut_addr = pa[vidx][FCW_WIDTH-1 -: ADDR_WIDTH];

  // Disabled voices sit at midscale so they add no DC offset.
  assign contrib = en[vidx] ? AW'(lut_code) : AW'(MID_CODE);

  sine_lut #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CODE_WIDTH(CODE_WIDTH)
  ) u_lut (
    .addr(lut_addr),
    .code(lut_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vidx       <= '0;
      acc        <= '0;
      code       <= MID_CODE;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
      en         <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        pa[i]  <= '0;
        fcw[i] <= '0;
      end
    end else begin
      code_valid <= 1'b0;
      overrun    <= 1'b0;

      // Only possible in IDLE, so never races the RUN update of pa.
      if (cfg_fire) begin
        fcw[cfg_voice] <= cfg_fcw;
        en[cfg_voice]  <= cfg_en;
        if (cfg_phase_clr) begin
          pa[cfg_voice] <= '0;
        end
      end

      if (next_sample && state != IDLE) begin
        overrun <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (next_sample) begin
            acc   <= '0;
            vidx  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc + contrib;
          if (en[vidx]) begin
            pa[vidx] <= pa[vidx] + fcw[vidx];
          end
          vidx <= vidx + VW'(1);
          if (vidx == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          code       <= CODE_WIDTH'(acc >> VW);
          code_valid <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Scoreboard bench for nco_voice_scheduler with hand-computed LUT sums.
// Stimulus pushes expected code and due cycle; a negedge monitor checks them.
module tb_nco_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        next_sample = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_voice = '0;
  logic [23:0] cfg_fcw = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_phase_clr = 1'b0;
  logic [13:0] code;
  logic        code_valid;
  logic        busy;
  logic        overrun;

  nco_voice_scheduler dut (
    .clk(clk),
    .rst_n(rst_n),
    .next_sample(next_sample),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_voice(cfg_voice),
    .cfg_fcw(cfg_fcw),
    .cfg_en(cfg_en),
    .cfg_phase_clr(cfg_phase_clr),
    .code(code),
    .code_valid(code_valid),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int cv_seen = 0;
  int ov_seen = 0;

  typedef struct {
    int code;
    int due;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (overrun === 1'b1) ov_seen++;
    if (code_valid === 1'b1) begin
      cv_seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_code_valid actual=%0d required=none",
                 code);
      end else begin
        e = sb.pop_front();
        check("code", 32'(code), 32'(e.code));
        check("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Strobe driven at negedge n is sampled at edge n+1; result visible
  // after edge n+6, i.e. at the negedge where cyc == n+6.
  task automatic strobe(input int exp_code);
    @(negedge clk);
    next_sample = 1'b1;
    sb.push_back('{exp_code, cyc + 6});
    @(negedge clk);
    next_sample = 1'b0;
  endtask

  // Strobe followed by the minimum legal spacing of NUM_VOICES+2.
  task automatic strobe_min(input int exp_code);
    strobe(exp_code);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL timeout_idle actual=%0d required=0", sb.size());
    end
  endtask

  task automatic cfg_write(input int v, input logic [23:0] f,
                           input logic e, input logic clr);
    int n;
    @(negedge clk);
    cfg_valid     = 1'b1;
    cfg_voice     = 2'(v);
    cfg_fcw       = f;
    cfg_en        = e;
    cfg_phase_clr = clr;
    n = 0;
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL timeout_cfg actual=%0d required=1", cfg_ready);
    end
    @(negedge clk);
    cfg_valid     = 1'b0;
    cfg_phase_clr = 1'b0;
  endtask

  initial begin
    int ov0;
    int cv0;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_code", 32'(code), 32'h2000);
    check("reset_cfg_ready", 32'(cfg_ready), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_code_valid", 32'(code_valid), 0);
    check("reset_overrun", 32'(overrun), 0);
    rst_n = 1'b1;

    // Reset in the middle of a frame
    @(negedge clk);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    @(negedge clk);
    check("busy_in_run", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 0);
    check("midreset_code", 32'(code), 32'h2000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midreset_no_valid", 32'(cv_seen), 0);

    // Silence: all voices disabled
    strobe(8192);
    wait_idle();

    // Single voice: lut(0)=8192, lut(1)=8445, lut(2)=8695
    cfg_write(0, 24'h010000, 1'b1, 1'b1);
    strobe(8192);
    wait_idle();
    strobe(8255);
    wait_idle();
    strobe(8317);
    wait_idle();

    // Wrap-around on voice 1: lut(FF)=7939, lut(FE)=7689
    cfg_write(0, 24'h010000, 1'b0, 1'b0);
    cfg_write(1, 24'hFF0000, 1'b1, 1'b1);
    strobe(8192);
    wait_idle();
    strobe(8128);
    wait_idle();
    strobe(8066);
    wait_idle();

    // Overrun: second strobe two cycles in; lut(FD)=7443 then lut(FC)=7201
    ov0 = ov_seen;
    cv0 = cv_seen;
    @(negedge clk);
    next_sample = 1'b1;
    sb.push_back('{8004, cyc + 6});
    @(negedge clk);
    next_sample = 1'b0;
    @(negedge clk);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("overrun_pulses", 32'(ov_seen - ov0), 1);
    check("overrun_one_valid", 32'(cv_seen - cv0), 1);
    strobe(7944);
    wait_idle();

    // Config and strobe together: new fcw applies; lut(FB)=6963
    @(negedge clk);
    cfg_valid     = 1'b1;
    cfg_voice     = 2'd1;
    cfg_fcw       = 24'h020000;
    cfg_en        = 1'b1;
    cfg_phase_clr = 1'b0;
    next_sample   = 1'b1;
    check("collide_cfg_ready", 32'(cfg_ready), 1);
    sb.push_back('{7884, cyc + 6});
    @(negedge clk);
    cfg_valid   = 1'b0;
    next_sample = 1'b0;
    wait_idle();
    strobe(8004);
    wait_idle();

    // Config during RUN waits for IDLE; frame in flight is unchanged
    @(negedge clk);
    next_sample = 1'b1;
    sb.push_back('{8128, cyc + 6});
    @(negedge clk);
    next_sample   = 1'b0;
    cfg_valid     = 1'b1;
    cfg_voice     = 2'd1;
    cfg_fcw       = 24'h000000;
    cfg_en        = 1'b0;
    cfg_phase_clr = 1'b0;
    check("cfg_ready_run", 32'(cfg_ready), 0);
    n = 0;
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cfg_wait_cycles", 32'(n), 5);
    check("cfg_accept_busy", 32'(busy), 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_idle();
    strobe(8192);
    wait_idle();

    // All voices, strobes at minimum spacing
    cfg_write(0, 24'h010000, 1'b1, 1'b1);
    cfg_write(1, 24'h020000, 1'b1, 1'b1);
    cfg_write(2, 24'h030000, 1'b1, 1'b1);
    cfg_write(3, 24'h040000, 1'b1, 1'b1);
    ov0 = ov_seen;
    strobe_min(8192);
    strobe_min(8816);
    strobe_min(9411);
    strobe_min(9976);
    wait_idle();
    check("train_no_overrun", 32'(ov_seen - ov0), 0);

    // All voices at peak: acc = 4*0x3FFF must not overflow
    for (int v = 0; v < 4; v++) begin
      cfg_write(v, 24'h400000, 1'b1, 1'b1);
    end
    strobe(8192);
    wait_idle();
    strobe(16383);
    wait_idle();

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_voice_scheduler.md
# nco_voice_scheduler

Time-multiplexes one shared `sine_lut` across `NUM_VOICES` independent phase accumulators, producing one mixed 14-bit DAC code per audio sample. It sits between the audio sample-rate strobe (`next_sample`) and the DAC code path, replacing single-voice NCO use. A small config port sets each voice's frequency control word, enable and phase reset.

## Interface
- `NUM_VOICES`, 4: voice count; power of two, 2..8.
- `FCW_WIDTH`, 24: phase accumulator and FCW width.
- `ADDR_WIDTH`, 8: LUT address width; address = top `ADDR_WIDTH` bits of the accumulator.
- `CODE_WIDTH`, 14: LUT/output code width, offset binary; midscale = 2^(CODE_WIDTH-1).
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `next_sample`  in  1  one-cycle sample strobe.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  config write accepted when `cfg_valid && cfg_ready`.
- `cfg_voice`  in  log2(NUM_VOICES)  target voice.
- `cfg_fcw`  in  FCW_WIDTH  new FCW.
- `cfg_en`  in  1  new voice enable.
- `cfg_phase_clr`  in  1  clear target accumulator on write.
- `code`  out  CODE_WIDTH  mixed output code.
- `code_valid`  out  1  one-cycle pulse when `code` updates.
- `busy`  out  1  frame in progress.
- `overrun`  out  1  one-cycle pulse when `next_sample` is dropped.

## Operation
- Per-voice state: `pa[v]`, `fcw[v]`, `en[v]`. On reset, all are 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE, `next_sample`=1: clear `acc` and `vidx`, go to RUN.
  - RUN, one voice per cycle at `vidx`:
    - `addr = pa[vidx][FCW_WIDTH-1 -: ADDR_WIDTH]`.
    - `acc += en ? lut(addr) : MIDSCALE`.
    - If enabled, `pa[vidx] <= pa[vidx] + fcw[vidx]`, mod 2^FCW_WIDTH with silent wrap.
    - `vidx++`. After `vidx == NUM_VOICES-1`, go to DONE.
  - DONE: `code <= acc >> log2(NUM_VOICES)`, pulse `code_valid`, go to IDLE.
- The lookup uses the pre-increment phase: the first frame after a clear reads address 0.
- `acc` width is CODE_WIDTH+log2(NUM_VOICES) and never saturates. A disabled voice contributes midscale and its `pa` is held.
- `cfg_ready` = (state == IDLE).
  - An accepted write updates `fcw`/`en` next cycle.
  - If `cfg_phase_clr`=1, it also sets `pa` to 0.
- Config write and `next_sample` in the same IDLE cycle: both are accepted, and the frame uses the new values.
- `next_sample` in RUN or DONE: ignored, `overrun` pulses that cycle, and the frame in progress completes unchanged.
- Reset mid-frame: immediately returns to IDLE with all registers at reset values. No `code_valid` is emitted.

## Timing
- Reset values:
  - `code` = MIDSCALE (0x2000 at default widths).
  - `code_valid`, `busy`, `overrun` = 0.
  - `cfg_ready` = 1.
- `next_sample` sampled high at edge t gives RUN on cycles t+1..t+NUM_VOICES and DONE at t+NUM_VOICES+1. `code`/`code_valid` are visible after edge t+NUM_VOICES+1, i.e. latency NUM_VOICES+1 = 5 cycles at default.
- `busy` = (state != IDLE). The next strobe can be accepted on the cycle after DONE, so the minimum strobe spacing is NUM_VOICES+2 cycles.
- `code` holds its value between frames.
- All outputs are registered except `cfg_ready` and `busy` (decoded from the state register).
- The LUT is combinational, so lookup and accumulate happen in the same cycle.

## Structure
- Package `nco_pkg` holds:
  - the default width constants and `MIDSCALE`;
  - the state enum `{IDLE, RUN, DONE}`;
  - the `log2(NUM_VOICES)` constant function.
- One sub-module: the existing `sine_lut`, instantiated exactly once. Everything else (per-voice register file, FSM, accumulator) is flat in this module.

## Test plan
- **Reset and silence.** Assert `rst_n`=0 mid-frame, release, pulse `next_sample` with all voices disabled.
  - `code` = 0x2000 during reset.
  - After the strobe, `code_valid` at +5 cycles with `code` = 0x2000.
- **Single voice.** Voice 0: `fcw` = 0x010000, enabled, `cfg_phase_clr`=1; voices 1..3 disabled. Issue 3 strobes.
  - `code` = (lut(k) + 3·0x2000) >> 2 for k = 0, 1, 2.
- **Wrap-around.** Voice 1: `fcw` = 0xFF0000, `cfg_phase_clr`=1. Issue 3 strobes.
  - Addresses read are 0x00, 0xFF, 0xFE.
  - `pa` wraps silently with no other side effect.
- **All voices.** Four voices with fcw = 0x010000, 0x020000, 0x030000, 0x040000 on a long strobe train.
  - `code` matches the reference model sum >> 2 every frame.
  - `acc` reaches 4·0x3FFF without overflow when all LUT outputs are at max.
- **Overrun.** Issue a second `next_sample` 2 cycles after the first.
  - `overrun` pulses once.
  - Exactly one `code_valid`.
  - `pa` advanced exactly once.
- **Config/strobe collision.** `cfg_valid` and `next_sample` together in IDLE: the frame uses the new FCW.
  - `cfg_valid` during RUN: `cfg_ready`=0 and the write is accepted only after return to IDLE.
